// File: rtl/lbp_host_mem.sv
// lbp_host_mem: responder side of the LBP engine's gray/lbp memory interface.
// Loads one IMG_W x IMG_H gray image over a valid/ready byte stream, serves
// the engine's combinational gray reads, captures its result writes, and
// streams the result buffer out in raster order once the engine finishes.
// Optional build macro LBP_HOST_CHECK_EN adds the wr_cnt / err write monitor.
module lbp_host_mem #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic              gray_ready,
    input  logic [ADDR_W-1:0] gray_addr,
    input  logic              gray_req,
    output logic [7:0]        gray_data,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic              lbp_valid,
    input  logic [7:0]        lbp_data,
    input  logic              finish,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic              done
`ifdef LBP_HOST_CHECK_EN
    ,
    output logic [ADDR_W:0]   wr_cnt,
    output logic              err
`endif
);

    localparam int N  = IMG_W * IMG_H;
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] N_P    = PW'(N);
    localparam logic [PW-1:0] LAST_P = PW'(N - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SERVE, DUMP, DONE} state_t;

    logic [7:0] img [N];
    logic [7:0] res [N];

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d, ptr_inc;
    logic            ld_ready_q, ld_ready_d;
    logic            gray_ready_q, gray_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            done_q, done_d;

    logic            img_we;
    logic            res_we;
    logic [ADDR_W-1:0] res_waddr;
    logic [7:0]      res_wdata;
    logic            gray_in_range;
    logic            lbp_in_range;

    // gray_req is advisory only; reads are served regardless of it.
    logic            unused_gray_req;
    assign unused_gray_req = gray_req;

    assign ptr_inc       = ptr_q + PW'(1);
    assign gray_in_range = ({1'b0, gray_addr} < N_P);
    assign lbp_in_range  = ({1'b0, lbp_addr} < N_P);

    // Zero-latency image read for the engine; out-of-range addresses read 0.
    assign gray_data = gray_in_range ? img[gray_addr] : 8'h00;

    // Next-state, pointer, memory write port and dump output stage.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        img_we      = 1'b0;
        res_we      = 1'b0;
        res_waddr   = ptr_q[ADDR_W-1:0];
        res_wdata   = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                // Each accepted pixel also clears its result slot so border
                // pixels the engine never writes dump as 0.
                if (ld_valid) begin
                    img_we = 1'b1;
                    res_we = 1'b1;
                    ptr_d  = ptr_inc;
                    if (ptr_q == LAST_P) begin
                        state_d = SERVE;
                        ptr_d   = '0;
                    end
                end
            end
            SERVE: begin
                if (lbp_valid && lbp_in_range) begin
                    res_we    = 1'b1;
                    res_waddr = lbp_addr;
                    res_wdata = lbp_data;
                end
                if (finish) begin
                    state_d     = DUMP;
                    out_valid_d = 1'b1;
                    // Bypass a same-cycle write to address 0 so the first
                    // dumped byte reflects it.
                    out_data_d  = (res_we && (lbp_addr == '0)) ? lbp_data : res[0];
                end
            end
            DUMP: begin
                if (out_ready) begin
                    if (ptr_q == LAST_P) begin
                        state_d     = DONE;
                        out_valid_d = 1'b0;
                        out_data_d  = 8'h00;
                    end else begin
                        ptr_d      = ptr_inc;
                        out_data_d = res[ptr_inc[ADDR_W-1:0]];
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ld_ready_d   = (state_d == LOAD);
        gray_ready_d = (state_d == SERVE);
        done_d       = (state_d == DONE);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            ld_ready_q   <= 1'b0;
            gray_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ld_ready_q   <= ld_ready_d;
            gray_ready_q <= gray_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            done_q       <= done_d;
        end
    end

    // Image and result storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (img_we) begin
            img[ptr_q[ADDR_W-1:0]] <= ld_data;
        end
        if (res_we) begin
            res[res_waddr] <= res_wdata;
        end
    end

    assign ld_ready   = ld_ready_q;
    assign gray_ready = gray_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign done       = done_q;

`ifdef LBP_HOST_CHECK_EN
    logic [PW-1:0] wr_cnt_q;
    logic          err_q;
    logic          border_hit;
    int            chk_row;
    int            chk_col;

    // Classify the write address as lying on the image border.
    always_comb begin
        chk_row    = int'(lbp_addr) / IMG_W;
        chk_col    = int'(lbp_addr) % IMG_W;
        border_hit = (chk_row == 0) || (chk_row == IMG_H - 1) ||
                     (chk_col == 0) || (chk_col == IMG_W - 1);
    end

    // Count engine writes during SERVE and flag border or out-of-range ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
        end else if ((state_q == SERVE) && lbp_valid) begin
            wr_cnt_q <= wr_cnt_q + PW'(1);
            if (!lbp_in_range || border_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign wr_cnt = wr_cnt_q;
    assign err    = err_q;
`endif

endmodule
